// File: rtl/hangman_pkg.sv
// Shared constants and state type for the Hangman host-side LCD formatter.
// Imported by the row-centering helper and the display generator top.
package hangman_pkg;

    localparam logic [7:0] ASCII_BLANK = 8'h5F;  // '_'
    localparam logic [7:0] ASCII_SPACE = 8'h20;  // ' '

    localparam logic [23:0] WIN_STR  = 24'h57_49_4E;     // "WIN"
    localparam logic [31:0] LOSE_STR = 32'h4C_4F_53_45;  // "LOSE"

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } host_state_t;

endpackage

// File: rtl/lcd_center_row.sv
// Places an N-character field centred in an LCD_CHARS-wide row, padding with spaces.
// Leftmost character lives in the MSBs of both the field and the row.
module lcd_center_row
    import hangman_pkg::*;
#(
    parameter int N         = 5,
    parameter int LCD_CHARS = 16
) (
    input  logic [8*N-1:0]         field,
    output logic [8*LCD_CHARS-1:0] row
);

    localparam int PAD = (LCD_CHARS - N) / 2;

    generate
        for (genvar gi = 0; gi < LCD_CHARS; gi++) begin : g_char
            if (gi >= PAD && gi < PAD + N) begin : g_field
                assign row[8*(LCD_CHARS-gi)-1 -: 8] = field[8*(N-(gi-PAD))-1 -: 8];
            end else begin : g_pad
                assign row[8*(LCD_CHARS-gi)-1 -: 8] = ASCII_SPACE;
            end
        end
    endgenerate

endmodule

// File: rtl/hangman_display_gen.sv
// Hangman host display: tracks revealed word, miss list, counters and PLAY/WIN/LOSE,
// and renders two registered ASCII LCD rows from the next-cycle state.
module hangman_display_gen
    import hangman_pkg::*;
#(
    parameter int WORD_LEN   = 5,
    parameter int MAX_MISSES = 6,
    parameter int LCD_CHARS  = 16
) (
    input  logic                               clk,
    input  logic                               nRst,
    input  logic                               guess_valid,
    input  logic [7:0]                         letter,
    input  logic [WORD_LEN-1:0]                index_correct,
    input  logic [8*WORD_LEN-1:0]              word,
    input  logic                               game_end,
    output logic [8*LCD_CHARS-1:0]             top,
    output logic [8*LCD_CHARS-1:0]             bottom,
    output logic [$clog2(WORD_LEN+1)-1:0]      correct_cnt,
    output logic [$clog2(MAX_MISSES+1)-1:0]    miss_cnt,
    output logic                               win,
    output logic                               lose,
    output logic                               dup_guess
);

    localparam int CW = $clog2(WORD_LEN + 1);
    localparam int MW = $clog2(MAX_MISSES + 1);

    function automatic logic [8*LCD_CHARS-1:0] blank_row(input int n);
        logic [8*LCD_CHARS-1:0] r;
        int pad;
        pad = (LCD_CHARS - n) / 2;
        for (int j = 0; j < LCD_CHARS; j++) begin
            r[8*(LCD_CHARS-j)-1 -: 8] = (j >= pad && j < pad + n) ? ASCII_BLANK : ASCII_SPACE;
        end
        return r;
    endfunction

    // Reset renders the cleared PLAY screen rather than zeros.
    localparam logic [8*LCD_CHARS-1:0] RST_TOP    = blank_row(WORD_LEN);
    localparam logic [8*LCD_CHARS-1:0] RST_BOTTOM = blank_row(MAX_MISSES);

    host_state_t                 state_q, state_d;
    logic [8*WORD_LEN-1:0]       revealed_q, revealed_d;
    logic [8*MAX_MISSES-1:0]     misses_q, misses_d;
    logic [CW-1:0]               correct_q, correct_d;
    logic [MW-1:0]               miss_cnt_q, miss_cnt_d;
    logic                        win_q, win_d;
    logic                        lose_q, lose_d;
    logic                        dup_q, dup_d;
    logic [8*LCD_CHARS-1:0]      top_q, top_d;
    logic [8*LCD_CHARS-1:0]      bottom_q, bottom_d;

    logic [WORD_LEN-1:0]         unrevealed;
    logic [WORD_LEN-1:0]         new_hits;
    logic                        is_miss;
    logic                        miss_seen;
    logic                        is_dup;
    logic                        take_guess;

    always_comb begin
        unrevealed = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            unrevealed[i] = (revealed_q[8*i +: 8] == ASCII_BLANK);
        end
        new_hits = index_correct & unrevealed;
        is_miss  = (index_correct == '0);

        // Only the filled (leftmost miss_cnt) slots count as previous misses.
        miss_seen = 1'b0;
        for (int s = 0; s < MAX_MISSES; s++) begin
            if ((MW'(s) < miss_cnt_q) && (misses_q[8*(MAX_MISSES-s)-1 -: 8] == letter)) begin
                miss_seen = 1'b1;
            end
        end

        is_dup     = is_miss ? miss_seen : (new_hits == '0);
        take_guess = (state_q == PLAY) && guess_valid && !game_end;
    end

    always_comb begin
        state_d    = state_q;
        revealed_d = revealed_q;
        misses_d   = misses_q;
        correct_d  = correct_q;
        miss_cnt_d = miss_cnt_q;
        dup_d      = 1'b0;

        if (game_end) begin
            state_d    = PLAY;
            revealed_d = {WORD_LEN{ASCII_BLANK}};
            misses_d   = {MAX_MISSES{ASCII_BLANK}};
            correct_d  = '0;
            miss_cnt_d = '0;
        end else if (take_guess) begin
            if (is_dup) begin
                dup_d = 1'b1;
            end else if (is_miss) begin
                misses_d = misses_q >> 8;
                misses_d[8*MAX_MISSES-1 -: 8] = letter;
                miss_cnt_d = miss_cnt_q + 1'b1;
                if (miss_cnt_d == MW'(MAX_MISSES)) begin
                    state_d = LOSE;
                end
            end else begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    if (new_hits[i]) begin
                        revealed_d[8*i +: 8] = letter;
                    end
                end
                correct_d = '0;
                for (int i = 0; i < WORD_LEN; i++) begin
                    if (revealed_d[8*i +: 8] != ASCII_BLANK) begin
                        correct_d = correct_d + 1'b1;
                    end
                end
                if (correct_d == CW'(WORD_LEN)) begin
                    state_d = WIN;
                end
            end
        end

        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    // "WIN" is one char shorter than "LOSE"; padding it to 4 chars on the side
    // matching the row parity gives the same left offset as centring 3 chars.
    logic [31:0]             msg_field;
    logic [8*LCD_CHARS-1:0]  row_revealed;
    logic [8*LCD_CHARS-1:0]  row_misses;
    logic [8*LCD_CHARS-1:0]  row_msg;
    logic [8*LCD_CHARS-1:0]  row_word;

    always_comb begin
        if (state_d == LOSE) begin
            msg_field = LOSE_STR;
        end else if (LCD_CHARS % 2 == 0) begin
            msg_field = {WIN_STR, ASCII_SPACE};
        end else begin
            msg_field = {ASCII_SPACE, WIN_STR};
        end
    end

    lcd_center_row #(.N(WORD_LEN), .LCD_CHARS(LCD_CHARS)) u_row_revealed (
        .field (revealed_d),
        .row   (row_revealed)
    );

    lcd_center_row #(.N(MAX_MISSES), .LCD_CHARS(LCD_CHARS)) u_row_misses (
        .field (misses_d),
        .row   (row_misses)
    );

    lcd_center_row #(.N(4), .LCD_CHARS(LCD_CHARS)) u_row_msg (
        .field (msg_field),
        .row   (row_msg)
    );

    lcd_center_row #(.N(WORD_LEN), .LCD_CHARS(LCD_CHARS)) u_row_word (
        .field (word),
        .row   (row_word)
    );

    always_comb begin
        top_d    = row_revealed;
        bottom_d = row_misses;
        if (state_d != PLAY) begin
            top_d    = row_msg;
            bottom_d = row_word;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= PLAY;
            revealed_q <= {WORD_LEN{ASCII_BLANK}};
            misses_q   <= {MAX_MISSES{ASCII_BLANK}};
            correct_q  <= '0;
            miss_cnt_q <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            dup_q      <= 1'b0;
            top_q      <= RST_TOP;
            bottom_q   <= RST_BOTTOM;
        end else begin
            state_q    <= state_d;
            revealed_q <= revealed_d;
            misses_q   <= misses_d;
            correct_q  <= correct_d;
            miss_cnt_q <= miss_cnt_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            dup_q      <= dup_d;
            top_q      <= top_d;
            bottom_q   <= bottom_d;
        end
    end

    assign top         = top_q;
    assign bottom      = bottom_q;
    assign correct_cnt = correct_q;
    assign miss_cnt    = miss_cnt_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign dup_guess   = dup_q;

endmodule

// File: tb/tb_hangman_display_gen.sv
// Directed plus randomized bench for hangman_display_gen against a character-level
// game model (byte arrays and a miss queue) rendered with simple centring arithmetic.
module tb_hangman_display_gen;

    localparam int WL = 5;
    localparam int MM = 6;
    localparam int LC = 16;

    logic               clk = 1'b0;
    logic               nRst;
    logic               guess_valid;
    logic [7:0]         letter;
    logic [WL-1:0]      index_correct;
    logic [8*WL-1:0]    word;
    logic               game_end;
    logic [8*LC-1:0]    top;
    logic [8*LC-1:0]    bottom;
    logic [2:0]         correct_cnt;
    logic [2:0]         miss_cnt;
    logic               win;
    logic               lose;
    logic               dup_guess;

    int errors = 0;
    int checks = 0;

    hangman_display_gen #(.WORD_LEN(WL), .MAX_MISSES(MM), .LCD_CHARS(LC)) dut (
        .clk           (clk),
        .nRst          (nRst),
        .guess_valid   (guess_valid),
        .letter        (letter),
        .index_correct (index_correct),
        .word          (word),
        .game_end      (game_end),
        .top           (top),
        .bottom        (bottom),
        .correct_cnt   (correct_cnt),
        .miss_cnt      (miss_cnt),
        .win           (win),
        .lose          (lose),
        .dup_guess     (dup_guess)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    byte unsigned m_rev[WL];      // revealed word, index 0 = leftmost
    byte unsigned m_miss[$];      // misses, newest first
    int           m_st;           // 0 play, 1 win, 2 lose
    bit           m_dup;
    logic [8*WL-1:0] m_word;

    function automatic void m_clear();
        for (int k = 0; k < WL; k++) m_rev[k] = 8'h5F;
        m_miss.delete();
        m_st  = 0;
        m_dup = 0;
    endfunction

    function automatic void m_step(bit gv, byte unsigned l, logic [WL-1:0] idx, bit ge);
        bit seen;
        int fresh;
        int n;
        m_dup  = 0;
        m_word = word;
        if (ge) begin
            m_clear();
        end else if (gv && m_st == 0) begin
            if (idx == 0) begin
                seen = 0;
                foreach (m_miss[q]) if (m_miss[q] == l) seen = 1;
                if (seen) m_dup = 1;
                else begin
                    m_miss.push_front(l);
                    if (m_miss.size() == MM) m_st = 2;
                end
            end else begin
                fresh = 0;
                for (int k = 0; k < WL; k++) begin
                    if (idx[WL-1-k] && m_rev[k] == 8'h5F) begin
                        m_rev[k] = l;
                        fresh++;
                    end
                end
                if (fresh == 0) m_dup = 1;
                else begin
                    n = 0;
                    for (int k = 0; k < WL; k++) if (m_rev[k] != 8'h5F) n++;
                    if (n == WL) m_st = 1;
                end
            end
        end
    endfunction

    function automatic logic [8*LC-1:0] center(byte unsigned f[$]);
        byte unsigned cells[LC];
        logic [8*LC-1:0] r;
        int pad;
        pad = (LC - f.size()) / 2;
        foreach (cells[j]) cells[j] = 8'h20;
        foreach (f[k]) cells[pad + k] = f[k];
        foreach (cells[j]) r[8*(LC-j)-1 -: 8] = cells[j];
        return r;
    endfunction

    function automatic logic [8*LC-1:0] word_row();
        byte unsigned f[$];
        for (int k = 0; k < WL; k++) f.push_back(m_word[8*(WL-1-k) +: 8]);
        return center(f);
    endfunction

    function automatic logic [8*LC-1:0] exp_top();
        byte unsigned f[$];
        if (m_st == 1) f = {8'h57, 8'h49, 8'h4E};
        else if (m_st == 2) f = {8'h4C, 8'h4F, 8'h53, 8'h45};
        else foreach (m_rev[k]) f.push_back(m_rev[k]);
        return center(f);
    endfunction

    function automatic logic [8*LC-1:0] exp_bottom();
        byte unsigned f[$];
        if (m_st != 0) return word_row();
        f = m_miss;
        while (f.size() < MM) f.push_back(8'h5F);
        return center(f);
    endfunction

    function automatic int exp_correct();
        int n;
        n = 0;
        foreach (m_rev[k]) if (m_rev[k] != 8'h5F) n++;
        return n;
    endfunction

    function automatic logic [WL-1:0] idx_of(logic [8*WL-1:0] w, byte unsigned l);
        logic [WL-1:0] r;
        for (int k = 0; k < WL; k++) r[WL-1-k] = (w[8*(WL-1-k) +: 8] == l);
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [8*LC-1:0] obs, logic [8*LC-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(string ctx);
        chk({ctx, " top"},         top,                exp_top());
        chk({ctx, " bottom"},      bottom,             exp_bottom());
        chk({ctx, " correct_cnt"}, 128'(correct_cnt),  128'(exp_correct()));
        chk({ctx, " miss_cnt"},    128'(miss_cnt),     128'(m_miss.size()));
        chk({ctx, " win"},         128'(win),          128'(m_st == 1));
        chk({ctx, " lose"},        128'(lose),         128'(m_st == 2));
        chk({ctx, " dup_guess"},   128'(dup_guess),    128'(m_dup));
    endtask

    // Called at a falling edge; applies one cycle of stimulus and checks after it.
    task automatic cyc(string ctx, bit gv, byte unsigned l, logic [WL-1:0] idx, bit ge);
        guess_valid   = gv;
        letter        = l;
        index_correct = idx;
        game_end      = ge;
        @(posedge clk);
        m_step(gv, l, idx, ge);
        @(negedge clk);
        guess_valid   = 1'b0;
        game_end      = 1'b0;
        index_correct = '0;
        check_all(ctx);
    endtask

    task automatic guess(string ctx, byte unsigned l);
        cyc(ctx, 1'b1, l, idx_of(word, l), 1'b0);
    endtask

    initial begin
        byte unsigned miss_seq[6];
        byte unsigned win_seq[4];
        int r;
        byte unsigned l;
        logic [WL-1:0] idx;

        nRst          = 1'b0;
        guess_valid   = 1'b0;
        game_end      = 1'b0;
        letter        = 8'h00;
        index_correct = '0;
        word          = "HELLO";
        m_word        = word;
        m_clear();

        @(negedge clk);
        check_all("reset_held");
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        check_all("reset");
        chk("reset top literal",    top,    "     _____      ");
        chk("reset bottom literal", bottom, "     ______     ");

        cyc("hit_L", 1'b1, "L", 5'b00110, 1'b0);
        chk("hit_L top literal", top, "     __LL_      ");
        cyc("dup_L", 1'b1, "L", 5'b00110, 1'b0);
        cyc("miss_Z", 1'b1, "Z", 5'b00000, 1'b0);
        chk("miss_Z bottom literal", bottom, "     Z_____     ");
        cyc("dup_Z", 1'b1, "Z", 5'b00000, 1'b0);

        miss_seq = '{"Q", "X", "J", "K", "V", "W"};
        for (int i = 0; i < 5; i++) cyc("miss_seq", 1'b1, miss_seq[i], 5'b00000, 1'b0);
        chk("lose top literal",    top,    "      LOSE      ");
        chk("lose bottom literal", bottom, "     HELLO      ");
        cyc("guess_in_lose", 1'b1, "H", 5'b10000, 1'b0);
        cyc("miss_in_lose", 1'b1, "W", 5'b00000, 1'b0);

        cyc("end_round", 1'b0, 8'h00, 5'b00000, 1'b1);
        win_seq = '{"H", "E", "L", "O"};
        foreach (win_seq[i]) guess("win_seq", win_seq[i]);
        chk("win top literal", top, "      WIN       ");
        word = "WORLD";
        cyc("win_word_change", 1'b0, 8'h00, 5'b00000, 1'b0);
        cyc("end_with_guess", 1'b1, "H", 5'b10000, 1'b1);
        chk("end_with_guess top literal", top, "     _____      ");

        word = "HELLO";
        guess("pre_reset_H", "H");
        guess("pre_reset_E", "E");
        nRst = 1'b0;
        #1;
        m_clear();
        check_all("async_reset");
        @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        check_all("async_reset_held");

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            l = 8'h41 + 8'($urandom_range(0, 7));
            if (r < 3 || (m_st != 0 && r < 30)) begin
                cyc("rand_end", 1'($urandom_range(0, 1)), l, idx_of(word, l), 1'b1);
            end else if (r < 8) begin
                for (int k = 0; k < WL; k++) word[8*k +: 8] = 8'h41 + 8'($urandom_range(0, 7));
                cyc("rand_word", 1'b0, 8'h00, 5'b00000, 1'b0);
            end else begin
                idx = (r < 15) ? WL'($urandom) : idx_of(word, l);
                cyc("rand_guess", 1'b1, l, idx, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
